sensors_to_pattern_v0: RTL and testbench

- Return-path counterpart of the pattern streamer.
- Accepts 64-bit sensor readback samples over a valid/ready handshake and packs four samples into each 256-bit word.
- Writes each packed word into the 256-bit-wide readback FIFO, honouring that FIFO's full flag.
- Frames are Num_Samp samples long, started by stream_en_i; a partial last word is zero-padded and flushed.

---
 rtl/sensors_to_pattern_v0.sv | 149 ++++++++++++++
 tb/tb_sensors_to_pattern_v0.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensors_to_pattern_v0.sv
// sensors_to_pattern_v0: packs SAMP_W-bit sensor samples LANES per word into the readback FIFO.
// Optional build macro SENSORS_FRAME_HEADER_EN prepends a header word to every frame.
module sensors_to_pattern_v0 #(
    parameter int SAMP_W = 64,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        Num_Samp,
    input  logic                    stream_en_i,
    output logic                    stream_en_o,
    input  logic [SAMP_W-1:0]       DI,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [SAMP_W*LANES-1:0] DO,
    output logic                    wr_en,
    input  logic                    full,
    output logic                    frame_done,
    output logic                    overflow,
    output logic [CNT_W-1:0]        frame_cnt
);
    localparam int WORD_W = SAMP_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
`ifdef SENSORS_FRAME_HEADER_EN
    localparam logic [1:0] S_HEADER  = 2'd1;
`endif
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    logic [1:0]        state;
    logic              en_q;
    logic [CNT_W-1:0]  remaining;
    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] pend_q;
    logic              pend_vld;

    logic              last_samp;
    logic              word_done;
    logic              accept;
    logic              start;
    logic [WORD_W-1:0] word_next;

    always_comb begin
        last_samp   = (remaining == CNT_W'(1));
        word_done   = (lane == LANE_W'(LANES - 1)) || last_samp;
        ready_o     = (state == S_CAPTURE) && !(pend_vld && word_done);
        accept      = valid_i && ready_o;
        start       = stream_en_i && !en_q && (Num_Samp != '0);
        stream_en_o = (state != S_IDLE);
        // Lanes above the current one are already zero, so a short last word is zero-padded.
        word_next = asm_q;
        word_next[lane*SAMP_W +: SAMP_W] = DI;
    end

`ifdef SENSORS_FRAME_HEADER_EN
    logic [WORD_W-1:0] hdr_word;

    always_comb begin
        hdr_word = '0;
        hdr_word[WORD_W-1 -: 32]            = 32'h5E45_0000;
        hdr_word[WORD_W-33 -: CNT_W]        = frame_cnt;
        hdr_word[WORD_W-33-CNT_W -: CNT_W]  = remaining;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            en_q       <= 1'b0;
            remaining  <= '0;
            lane       <= '0;
            asm_q      <= '0;
            pend_q     <= '0;
            pend_vld   <= 1'b0;
            DO         <= '0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            en_q       <= stream_en_i;
            frame_done <= 1'b0;

            if (pend_vld && !full) begin
                DO       <= pend_q;
                wr_en    <= 1'b1;
                pend_vld <= 1'b0;
            end else begin
                wr_en <= 1'b0;
            end

            // NOTE: non-blocking, so a word completing below overrides the drain above on the same edge.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= Num_Samp;
                        overflow  <= 1'b0;
                        lane      <= '0;
                        asm_q     <= '0;
`ifdef SENSORS_FRAME_HEADER_EN
                        state     <= S_HEADER;
`else
                        state     <= S_CAPTURE;
`endif
                    end
                end
`ifdef SENSORS_FRAME_HEADER_EN
                S_HEADER: begin
                    if (!pend_vld) begin
                        pend_q   <= hdr_word;
                        pend_vld <= 1'b1;
                        state    <= S_CAPTURE;
                    end
                end
`endif
                S_CAPTURE: begin
                    if (valid_i && !ready_o)
                        overflow <= 1'b1;
                    if (accept) begin
                        remaining <= remaining - CNT_W'(1);
                        if (word_done) begin
                            pend_q   <= word_next;
                            pend_vld <= 1'b1;
                            asm_q    <= '0;
                            lane     <= '0;
                            if (last_samp)
                                state <= S_FLUSH;
                        end else begin
                            asm_q <= word_next;
                            lane  <= lane + LANE_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (!pend_vld && !wr_en) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + CNT_W'(1);
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sensors_to_pattern_v0.sv
// Self-checking bench for sensors_to_pattern_v0: directed test-plan cases plus random frames
// checked against a queue-based packing model. Follows SENSORS_FRAME_HEADER_EN like the RTL.
module tb_sensors_to_pattern_v0;
`ifdef SENSORS_FRAME_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [15:0]  Num_Samp = '0;
    logic         stream_en_i = 1'b0;
    logic         stream_en_o;
    logic [63:0]  DI = '0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [255:0] DO;
    logic         wr_en;
    logic         full = 1'b0;
    logic         frame_done;
    logic         overflow;
    logic [15:0]  frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int w0 = 0;
    int full_mode = 0;
    logic [15:0]  model_cnt = '0;
    logic [63:0]  samp_q[$];
    logic [255:0] exp_q[$];

    sensors_to_pattern_v0 dut (
        .clk(clk), .reset(reset), .Num_Samp(Num_Samp), .stream_en_i(stream_en_i),
        .stream_en_o(stream_en_o), .DI(DI), .valid_i(valid_i), .ready_o(ready_o),
        .DO(DO), .wr_en(wr_en), .full(full), .frame_done(frame_done),
        .overflow(overflow), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (full_mode)
            0:       full = 1'b0;
            1:       full = ($urandom_range(0, 2) == 0);
            default: full = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (reset && wr_en) begin
            n_writes++;
            if (exp_q.size() == 0)
                check("wr_unexpected", {255'b0, wr_en}, 256'd0);
            else
                check("wr_data", DO, exp_q.pop_front());
        end
    end

    function automatic int words_for(input int n);
        return (n + 3) / 4 + HDR;
    endfunction

    task automatic build_frame(input int n, input bit seq);
        logic [255:0] word;
        samp_q.delete();
        for (int i = 0; i < n; i++)
            samp_q.push_back(seq ? 64'(i + 1) : {$urandom, $urandom});
        if (HDR != 0)
            exp_q.push_back({32'h5E45_0000, model_cnt, 16'(n), 192'b0});
        for (int w = 0; w < (n + 3) / 4; w++) begin
            word = '0;
            for (int l = 0; l < 4; l++)
                if (4 * w + l < n) word[l*64 +: 64] = samp_q[4*w+l];
            exp_q.push_back(word);
        end
    endtask

    task automatic start_frame(input int n);
        w0 = n_writes;
        Num_Samp = 16'(n);
        stream_en_i = 1'b1;
        @(posedge clk); #1;
        stream_en_i = 1'b0;
    endtask

    // Offers samp_q[0..n-1]; a polite source only asserts valid_i while ready_o is high.
    task automatic send(input int n, input bit rude, input int gap);
        int  k = 0;
        int  waited = 0;
        bit  drive, acc;
        while (k < n && waited < 500) begin
            drive = rude ? 1'b1 : (ready_o && ($urandom_range(0, 99) >= gap));
            valid_i = drive;
            DI = samp_q[k];
            acc = drive && ready_o;
            @(posedge clk); #1;
            if (acc) begin k++; waited = 0; end
            else waited++;
        end
        valid_i = 1'b0;
        if (k < n) check("send_timeout", k, n);
    endtask

    task automatic wait_done(input int n, input bit exp_ovf);
        bit got = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (frame_done) begin got = 1'b1; break; end
        end
        check("done_seen", {255'b0, got}, 256'd1);
        if (got) begin
            model_cnt = model_cnt + 16'd1;
            check("frame_cnt", frame_cnt, model_cnt);
            check("writes", n_writes - w0, words_for(n));
            check("overflow", overflow, exp_ovf);
            check("q_empty", exp_q.size(), 0);
            @(negedge clk);
            check("done_pulse", frame_done, 0);
            check("idle_stream_en_o", stream_en_o, 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_DO"}, DO, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_ready_o"}, ready_o, 0);
        check({tag, "_stream_en_o"}, stream_en_o, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Back-to-back 1..8, then a 5-sample frame with a zero-padded last word.
        build_frame(8, 1'b1); start_frame(8); send(8, 1'b0, 0); wait_done(8, 1'b0);
        build_frame(5, 1'b1); start_frame(5); send(5, 1'b0, 0); wait_done(5, 1'b0);

        // FIFO full stall with a polite source: ready_o drops, nothing is written, then both drain.
        full_mode = 2;
        @(posedge clk); #1;
        build_frame(8, 1'b0); start_frame(8);
        fork
            send(8, 1'b0, 0);
            begin
                repeat (12) @(posedge clk);
                #1;
                check("stall_ready_o", ready_o, 0);
                check("stall_no_write", n_writes - w0, 0);
                repeat (8) @(posedge clk);
                #1;
                full_mode = 0;
            end
        join
        wait_done(8, 1'b0);

        // Same stall with valid_i held high: overflow sets, persists, clears at next start.
        full_mode = 2;
        @(posedge clk); #1;
        build_frame(8, 1'b0); start_frame(8);
        fork
            send(8, 1'b1, 0);
            begin
                repeat (20) @(posedge clk);
                #1;
                full_mode = 0;
            end
        join
        wait_done(8, 1'b1);
        check("ovf_sticky", overflow, 1);
        build_frame(4, 1'b0); start_frame(4);
        check("ovf_cleared", overflow, 0);
        send(4, 1'b0, 0); wait_done(4, 1'b0);

        // Reset after 3 samples of an 8-sample frame: no write, everything back to zero.
        build_frame(8, 1'b0); start_frame(8); send(3, 1'b0, 0);
        reset = 1'b0;
        exp_q.delete();
        model_cnt = '0;
        @(negedge clk);
        check_all_zero("midrst");
        check("midrst_writes", n_writes - w0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        build_frame(6, 1'b0); start_frame(6); send(6, 1'b0, 10); wait_done(6, 1'b0);

        // Num_Samp == 0: start edge is ignored.
        Num_Samp = 16'd0;
        stream_en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zero_stream_en_o", stream_en_o, 0);
        end
        stream_en_i = 1'b0;
        @(posedge clk); #1;

        // Random frames with random source gaps and random FIFO backpressure.
        full_mode = 1;
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 20);
            build_frame(n, 1'b0);
            start_frame(n);
            send(n, 1'b0, $urandom_range(0, 40));
            wait_done(n, 1'b0);
        end
        full_mode = 0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
